dm_access_unit: RTL
===================

// Module: dm_access_unit
// PURPOSE
//  Sub-word load/store sequencer between the multi-cycle CPU datapath and the
//  byte-addressed, little-endian 1 KB data memory. That memory reads a word
//  combinationally and writes a full 32-bit word on posedge clk.
//  Handles lb/lbu/lh/lhu/lw/sb/sh/sw:
//  - extracts and extends load lanes;
//  - performs read-modify-write for byte/half stores;
//  - flags misaligned accesses.
// PARAMETERS
//  ADDR_W   10   byte-address width; must match the data memory address bus
// PORTS
//  clk       in   1       system clock, all state on posedge
//  rst_n     in   1       asynchronous active-low reset
//  req       in   1       access request, sampled only in IDLE
//  we        in   1       1 = store, 0 = load (sampled with req)
//  size      in   2       00 byte, 01 half, 10 word, 11 reserved
//  sign_ext  in   1       loads only: 1 = sign-extend, 0 = zero-extend
//  addr      in   ADDR_W  byte address of access
//  wdata     in   32      store data, lane in bits [7:0]/[15:0]/[31:0]
//  rdata     out  32      load result, registered, held until next load
//  done      out  1       1-cycle completion pulse
//  err       out  1       1-cycle misalign/reserved-size pulse, coincident with done
//  busy      out  1       high in every state except IDLE
//  dm_addr   out  ADDR_W  word-aligned address to memory ({addr_q[ADDR_W-1:2],2'b00})
//  dm_din    out  32      write data to memory
//  dm_we     out  1       memory write enable
//  dm_dout   in   32      combinational read data from memory at dm_addr
// BEHAVIOUR
//  Reset values (async, immediate): state=IDLE; rdata, dm_din, dm_addr = 0;
//  done, err, dm_we, busy = 0.
//  - Request capture: on req in IDLE, latch we, size, sign_ext, addr, wdata
//    into *_q. req outside IDLE is ignored; no queueing.
//  - Lane = addr_q[1:0].
//  - Misaligned conditions: half with lane[0]=1, word with lane!=0, or size=11.
//  - FSM states: IDLE, READ, WRITE, FIN, ERR.
//  - IDLE  -> ERR    req & misaligned
//  - IDLE  -> WRITE  req & we & size=10
//  - IDLE  -> READ   req, all other cases
//  - READ: dm_addr valid. Capture dm_dout into word_q.
//    - Load: rdata <= extracted lane; go to FIN.
//    - Store: go to WRITE.
//  - WRITE: dm_we=1.
//    - size=10: dm_din = wdata_q.
//    - size=01: dm_din = word_q with half lane[1] replaced by wdata_q[15:0].
//    - size=00: dm_din = word_q with byte lane replaced by wdata_q[7:0].
//    - Go to FIN.
//  - FIN: done=1; go to IDLE.
//  - ERR: done=1, err=1, no memory write, rdata unchanged; go to IDLE.
//  - Load extraction: byte = word_q[8*lane+:8]; half = word_q[16*lane[1]+:16].
//    Upper bits are the copied sign bit if sign_ext, else zeros.
//  - done/err are registered state decodes. dm_we is a combinational decode of
//    state==WRITE, so exactly one write edge occurs per store.
//  - Latency, counted from the req-sampling edge to the done-high cycle:
//    - load: 2 cycles
//    - word store: 2 cycles
//    - sub-word store: 3 cycles
//    - error: 1 cycle
//  - IDLE is re-entered the cycle after done, so the next req is accepted 1
//    cycle after done.
//  - Reset mid-operation: dm_we deasserts asynchronously, so no partial write
//    reaches memory. Any in-flight access is dropped without done.
//  - sign_ext is ignored for stores and for word loads.
// TESTING
//  1. Load sign: mem[0x10..0x13]=78 56 34 F2. lb addr=0x13 sign_ext=1 ->
//     rdata=0xFFFFFFF2, done 2 cycles after req. lbu -> 0x000000F2.
//  2. Half load: same data. lh addr=0x12 sign_ext=1 -> rdata=0xFFFFF234.
//     lhu addr=0x10 -> 0x00005678.
//  3. Byte store RMW: word 0x11223344 at 0x20. sb addr=0x21 wdata=0xAB ->
//     word at 0x20 becomes 0x1122AB44, exactly one dm_we cycle, done 3 cycles
//     after req.
//  4. Misaligned: lw addr=0x22, then sh addr=0x23, then size=11 -> err=done=1
//     1 cycle after req each time, dm_we never high, memory unchanged.
//  5. Back-to-back/busy: sw 0xDEADBEEF at 0x30, with req held high throughout ->
//     the second access starts only after IDLE is re-entered. lw 0x30 returns
//     0xDEADBEEF. req pulses during busy cause no extra accesses.
//  6. Reset in WRITE: start sh addr=0x40. Assert rst_n=0 while the FSM is in
//     WRITE -> dm_we drops immediately, memory at 0x40 unchanged, all outputs
//     at reset values, no done.

Source files
------------

// File: rtl/dm_access_unit.sv
// Sub-word load/store sequencer for a byte-addressed little-endian data memory.
// Ports: clk, rst_n (async low); req/we/size/sign_ext/addr/wdata request in;
//        rdata/done/err/busy status out; dm_addr/dm_din/dm_we/dm_dout memory side.
module dm_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        FIN,
        ERR
    } state_t;

    state_t state;

    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [1:0]  lane;
    logic        mis_req;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign lane    = addr_q[1:0];
    assign dm_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // Decoded from the request inputs: the check must be known on the same
    // edge that captures the request, to pick ERR directly from IDLE.
    always_comb begin
        mis_req = 1'b0;
        unique case (1'b1)
            (size == 2'b11): mis_req = 1'b1;
            (size == SZ_H):  mis_req = addr[0];
            (size == SZ_W):  mis_req = (addr[1:0] != 2'b00);
            default:         mis_req = 1'b0;
        endcase
    end

    always_comb begin
        byte_v   = dm_dout[{lane, 3'b000} +: 8];
        half_v   = dm_dout[{lane[1], 4'b0000} +: 16];
        load_val = dm_dout;
        case (size_q)
            SZ_B:    load_val = {{24{sext_q & byte_v[7]}}, byte_v};
            SZ_H:    load_val = {{16{sext_q & half_v[15]}}, half_v};
            default: load_val = dm_dout;
        endcase
    end

    // Read-modify-write merge; the read word is folded straight into the
    // registered write data, so it is held stable through WRITE.
    always_comb begin
        merged = dm_dout;
        if (size_q == SZ_B) begin
            merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end else if (size_q == SZ_H) begin
            merged[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Combinational so that async reset removes the write strobe at once.
    assign dm_we = (state == WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata   <= 32'h0;
            dm_din  <= 32'h0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= sign_ext;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (mis_req) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (we && size == SZ_W) begin
                            state  <= WRITE;
                            dm_din <= wdata;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        dm_din <= merged;
                        state  <= WRITE;
                    end else begin
                        rdata <= load_val;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                WRITE: begin
                    done  <= 1'b1;
                    state <= FIN;
                end
                FIN, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
